// File: rtl/cfs_apb_master_if.sv
// Command, response and APB signal bundle for cfs_apb_master.
// The master modport is the initiator's view; the slave modport is the view
// of whatever drives commands, consumes responses and models the APB slave.
interface cfs_apb_master_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    // Command channel
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;

    // Response channel
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;

    // APB3 bus
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic          psel;
    logic          penable;
    logic [DW-1:0] pwdata;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  rsp_ready,
        output paddr, pwrite, psel, penable, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output rsp_ready,
        input  paddr, pwrite, psel, penable, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/cfs_apb_master.sv
// APB3 initiator: turns single-beat commands into APB transfers, one at a
// time, and returns one response per command.
// Optional feature macro: CFS_APB_MASTER_TIMEOUT_EN
//   defined   - ACCESS is abandoned after TIMEOUT_CYCLES cycles without pready
//   undefined - ACCESS waits for pready indefinitely; rsp_timeout is tied to 0
module cfs_apb_master #(
    parameter int APB_ADDR_WIDTH = 16,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             reset,
    cfs_apb_master_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                    state;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic                      pwrite_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      rsp_valid_q;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
    logic                      rsp_err_q;

    // A zero timeout would make every transfer fail before the slave is asked.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("cfs_apb_master: TIMEOUT_CYCLES must be >= 1");
    end

`ifdef CFS_APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    // ACCESS cycles already spent without pready; stops at the limit.
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;
`endif

    // Transfer sequencer: IDLE -> SETUP -> ACCESS -> RESP -> IDLE, all outputs registered.
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef CFS_APB_MASTER_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        paddr_q  <= bus.cmd_addr;
                        pwrite_q <= bus.cmd_write;
                        pwdata_q <= bus.cmd_wdata;
                        psel_q   <= 1'b1;
                        state    <= SETUP;
                    end
                end

                SETUP: begin
                    penable_q <= 1'b1;
`ifdef CFS_APB_MASTER_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                    state     <= ACCESS;
                end

                ACCESS: begin
                    // pready is tested first so it wins over a timeout in the same cycle.
                    if (bus.pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= bus.pslverr;
                        rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
`ifdef CFS_APB_MASTER_TIMEOUT_EN
                        timeout_q   <= 1'b0;
`endif
                        state       <= RESP;
                    end
`ifdef CFS_APB_MASTER_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        // This idle cycle is the last one allowed: give up on the slave.
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        timeout_q   <= 1'b1;
                        wait_cnt    <= CNT_LIMIT;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // cmd_ready follows the state directly so it is already high in the
    // first cycle after reset, while every registered output is still 0.
    assign bus.cmd_ready = (state == IDLE);

    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

`ifdef CFS_APB_MASTER_TIMEOUT_EN
    assign bus.rsp_timeout = timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cfs_apb_master.sv
// Directed self-checking bench for cfs_apb_master.
// Inputs change and outputs are sampled on the falling edge; the DUT acts on
// the rising edge. Builds with or without CFS_APB_MASTER_TIMEOUT_EN.
module tb_cfs_apb_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    cfs_apb_master_if #(.AW(AW), .DW(DW)) bus ();

    cfs_apb_master #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case some step never returns.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a command in IDLE, check the SETUP cycle, and return at the
    // start of the first ACCESS cycle.
    task automatic start_cmd(input string tag, input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                             input logic slverr);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.pready    = 1'b0;
        bus.prdata    = rdata;
        bus.pslverr   = slverr;
        check({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        check({tag, ".setup_sel_en"}, 32'({bus.psel, bus.penable}), 32'b10);
        check({tag, ".setup_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
        check({tag, ".paddr"}, 32'(bus.paddr), 32'(addr));
        check({tag, ".pwrite"}, 32'(bus.pwrite), 32'(wr));
        check({tag, ".pwdata"}, bus.pwdata, wdata);
        tick();
    endtask

    // Full transfer up to the first RESP cycle; pready rises in ACCESS cycle 'waits'.
    task automatic issue(input string tag, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int waits,
                         input logic [DW-1:0] rdata, input logic slverr);
        start_cmd(tag, wr, addr, wdata, rdata, slverr);
        for (int i = 0; i <= waits; i++) begin
            bus.pready = (i == waits);
            check({tag, ".access_sel_en"}, 32'({bus.psel, bus.penable}), 32'b11);
            tick();
        end
        bus.pready = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [DW-1:0] exp_rdata,
                              input logic exp_err, input logic exp_to);
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".rsp_sel_en"}, 32'({bus.psel, bus.penable}), 32'b00);
        check({tag, ".rsp_rdata"}, bus.rsp_rdata, exp_rdata);
        check({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        check({tag, ".rsp_timeout"}, 32'(bus.rsp_timeout), 32'(exp_to));
    endtask

    task automatic finish_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check({tag, ".post_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".post_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.pready    = 1'b0;
        bus.prdata    = '0;
        bus.pslverr   = 1'b0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("reset.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("reset.sel_en", 32'({bus.psel, bus.penable}), 32'b00);
        check("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset.rsp_rdata", bus.rsp_rdata, 32'h0);
        check("reset.rsp_err", 32'({bus.rsp_err, bus.rsp_timeout}), 32'b00);
        check("reset.paddr", 32'(bus.paddr), 32'h0);
        check("reset.pwdata", bus.pwdata, 32'h0);

        // Zero-wait write; prdata is junk and must not reach rsp_rdata
        issue("wr0", 1'b1, 16'h0000, 32'h0000_0011, 0, 32'hA5A5_A5A5, 1'b0);
        expect_rsp("wr0", 32'h0, 1'b0, 1'b0);
        finish_rsp("wr0");
        check("wr0.paddr_held", 32'(bus.paddr), 32'h0000);
        check("wr0.pwdata_held", bus.pwdata, 32'h0000_0011);

        // Read with 3 wait states: ACCESS lasts 4 cycles
        issue("rd3", 1'b0, 16'h000C, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        expect_rsp("rd3", 32'hDEAD_BEEF, 1'b0, 1'b0);
        finish_rsp("rd3");

        // Slave error on a write
        issue("slverr", 1'b1, 16'h00F0, 32'h1234_5678, 0, 32'h5555_5555, 1'b1);
        expect_rsp("slverr", 32'h0, 1'b1, 1'b0);
        finish_rsp("slverr");

        // Slave error on a read still returns prdata
        issue("rderr", 1'b0, 16'h0010, 32'h0, 1, 32'h0BAD_F00D, 1'b1);
        expect_rsp("rderr", 32'h0BAD_F00D, 1'b1, 1'b0);
        finish_rsp("rderr");
        bus.pslverr = 1'b0;

`ifdef CFS_APB_MASTER_TIMEOUT_EN
        // pready held low: 16 ACCESS cycles, then a timeout response
        start_cmd("tmo", 1'b0, 16'h0020, 32'h0, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < TO; i++) begin
            check("tmo.access_sel_en", 32'({bus.psel, bus.penable}), 32'b11);
            tick();
        end
        expect_rsp("tmo", 32'h0, 1'b1, 1'b1);
        finish_rsp("tmo");

        // pready arrives in the cycle the counter would expire: normal completion
        issue("edge", 1'b0, 16'h0024, 32'h0, TO - 1, 32'hCAFE_0001, 1'b0);
        expect_rsp("edge", 32'hCAFE_0001, 1'b0, 1'b0);
        finish_rsp("edge");
`else
        // No timeout logic: ACCESS simply waits for a slow slave
        issue("slow", 1'b0, 16'h0020, 32'h0, 40, 32'hCAFE_0002, 1'b0);
        expect_rsp("slow", 32'hCAFE_0002, 1'b0, 1'b0);
        finish_rsp("slow");
`endif

        // Response back-pressure with a second command already waiting
        issue("bp", 1'b0, 16'h0004, 32'h0, 0, 32'h1357_9BDF, 1'b0);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 16'h0008;
        bus.cmd_wdata = 32'h2468_ACE0;
        for (int i = 0; i < 5; i++) begin
            check("bp.hold_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp.hold_rdata", bus.rsp_rdata, 32'h1357_9BDF);
            check("bp.hold_err", 32'({bus.rsp_err, bus.rsp_timeout}), 32'b00);
            check("bp.hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("bp.hold_sel", 32'(bus.psel), 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("bp.idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("bp.idle_sel", 32'(bus.psel), 32'd0);
        check("bp.idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        tick();
        bus.cmd_valid = 1'b0;
        check("bp2.setup_sel_en", 32'({bus.psel, bus.penable}), 32'b10);
        check("bp2.paddr", 32'(bus.paddr), 32'h0008);
        check("bp2.pwdata", bus.pwdata, 32'h2468_ACE0);
        bus.pready = 1'b1;
        tick();
        check("bp2.access_sel_en", 32'({bus.psel, bus.penable}), 32'b11);
        tick();
        bus.pready = 1'b0;
        expect_rsp("bp2", 32'h0, 1'b0, 1'b0);
        finish_rsp("bp2");

        // Reset pulse in the middle of ACCESS drops the transfer
        start_cmd("rst", 1'b0, 16'h0040, 32'h0, 32'h7777_7777, 1'b0);
        tick();
        check("rst.pre_sel_en", 32'({bus.psel, bus.penable}), 32'b11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst.sel_en", 32'({bus.psel, bus.penable}), 32'b00);
        check("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst.paddr", 32'(bus.paddr), 32'h0);
        bus.pready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("rst.no_rsp", 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        bus.pready = 1'b0;

        // The master still works after the mid-transfer reset
        issue("post", 1'b0, 16'h0044, 32'h0, 2, 32'h0F0F_0F0F, 1'b0);
        expect_rsp("post", 32'h0F0F_0F0F, 1'b0, 1'b0);
        finish_rsp("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
